// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial RV32I load/store sequencer for a byte-wide data memory
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_out_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [7:0]        mem_write_data,
  output logic              mem_we,
  input  logic [7:0]        mem_out_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic lwe;
  logic [2:0] lf3;
  logic [ADDR_W-1:0] laddr;
  logic [31:0] lwd, res, full, ext;
  logic [2:0] n, n_in;
  logic [1:0] k, k_nx;
  logic bad, last, acc;
  assign n_in = funct3[1:0] == 2'b00 ? 3'd1 : funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  assign bad = funct3 == 3'b011 || funct3[2:1] == 2'b11
            || (funct3[1:0] == 2'b01 && addr[0])
            || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign acc = state == IDLE && start;
  assign last = {1'b0, k} == n - 3'd1;
  assign k_nx = k + 2'd1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: faulting requests skip ACCESS and go straight to DONE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (bad ? DONE : ACCESS) : IDLE)
             : state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  // merge the byte being read this cycle into the result and extend it
  always_comb begin
    full = res;
    full[{k, 3'b000} +: 8] = mem_out_data;
    ext = lf3 == 3'b000 ? {{24{full[7]}}, full[7:0]}
        : lf3 == 3'b001 ? {{16{full[15]}}, full[15:0]}
        : lf3 == 3'b100 ? {24'd0, full[7:0]}
        : lf3 == 3'b101 ? {16'd0, full[15:0]} : full;
  end
  // request latch, byte sequencing and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lwe <= 1'b0;
      lf3 <= 3'd0;
      laddr <= '0;
      lwd <= 32'd0;
      n <= 3'd0;
      k <= 2'd0;
      res <= 32'd0;
      rdata <= 32'd0;
      fault <= 1'b0;
      mem_out_addr <= '0;
      mem_write_addr <= '0;
      mem_write_data <= 8'd0;
      mem_we <= 1'b0;
    end else if (acc) begin
      lwe <= we;
      lf3 <= funct3;
      laddr <= addr;
      lwd <= wdata;
      n <= n_in;
      k <= 2'd0;
      res <= 32'd0;
      rdata <= 32'd0;
      fault <= bad;
      mem_out_addr <= addr;
      mem_write_addr <= addr;
      mem_we <= we && !bad;
      mem_write_data <= (we && !bad) ? wdata[7:0] : 8'd0;
    end else if (state == ACCESS) begin
      if (!lwe) res <= full;
      if (last) begin
        k <= 2'd0;
        rdata <= lwe ? 32'd0 : ext;
        mem_we <= 1'b0;
        mem_write_data <= 8'd0;
        mem_out_addr <= laddr;
        mem_write_addr <= laddr;
      end else begin
        k <= k_nx;
        mem_we <= lwe;
        mem_write_data <= lwe ? lwd[{k_nx, 3'b000} +: 8] : 8'd0;
        mem_out_addr <= laddr + ADDR_W'(k_nx);
        mem_write_addr <= laddr + ADDR_W'(k_nx);
      end
    end
endmodule
